// File: rtl/bp_be_prefetch_scheduler.sv
// Prefetch scheduler: walks confirmed stride streams and issues line-aligned prefetches,
// with one pending stream slot and a small FIFO filter of recently issued lines.
module bp_be_prefetch_scheduler #(
   parameter int unsigned vaddr_width_p       = 39,
   parameter int unsigned stride_width_p      = 8,
   parameter int unsigned degree_max_p        = 4,
   parameter int unsigned filter_els_p        = 4,
   parameter int unsigned line_offset_width_p = 6,
   localparam int unsigned degree_width_lp    = $clog2(degree_max_p + 1)
) (
   input  logic                        clk_i,
   input  logic                        reset_i,
   input  logic                        enable_i,
   input  logic [degree_width_lp-1:0]  degree_i,
   input  logic                        confirm_v_i,
   input  logic [vaddr_width_p-1:0]    base_addr_i,
   input  logic [stride_width_p-1:0]   stride_i,
   input  logic                        flush_i,
   output logic                        pf_v_o,
   output logic [vaddr_width_p-1:0]    pf_addr_o,
   input  logic                        pf_ready_i,
   output logic                        busy_o,
   output logic                        dropped_o
);

   localparam int unsigned line_width_lp = vaddr_width_p - line_offset_width_p;
   localparam int unsigned ptr_width_lp  = (filter_els_p > 1) ? $clog2(filter_els_p) : 1;

   typedef enum logic [0:0] {StIdle, StIssue} state_e;

   state_e                      state_r;
   logic [vaddr_width_p-1:0]    cand_r;
   logic [stride_width_p-1:0]   stride_r;
   logic [degree_width_lp-1:0]  count_r;
   logic                        pv_r;
   logic [vaddr_width_p-1:0]    pend_base_r;
   logic [stride_width_p-1:0]   pend_stride_r;
   logic [degree_width_lp-1:0]  pend_degree_r;
   logic [filter_els_p-1:0]     filt_v_r;
   logic [line_width_lp-1:0]    filt_line_r [filter_els_p];
   logic [ptr_width_lp-1:0]     filt_ptr_r;
   logic                        dropped_r;

   logic [degree_width_lp-1:0]  degree_clamp;
   logic [line_width_lp-1:0]    cand_line;
   logic                        issuing;
   logic                        accept;
   logic                        hit;
   logic                        handshake;
   logic                        consume;
   logic                        last;
   logic                        load_en;
   logic                        pend_we;
   logic [vaddr_width_p-1:0]    load_base;
   logic [stride_width_p-1:0]   load_stride;
   logic [degree_width_lp-1:0]  load_degree;

   function automatic logic [vaddr_width_p-1:0] sext(input logic [stride_width_p-1:0] s);
      return {{(vaddr_width_p - stride_width_p){s[stride_width_p-1]}}, s};
   endfunction

   assign degree_clamp = (degree_i > degree_width_lp'(degree_max_p))
                         ? degree_width_lp'(degree_max_p) : degree_i;
   assign cand_line    = cand_r[vaddr_width_p-1:line_offset_width_p];
   assign issuing      = (state_r == StIssue);
   assign accept       = confirm_v_i & enable_i & (degree_i != '0);

   always_comb begin
      hit = 1'b0;
      for (int i = 0; i < int'(filter_els_p); i++) begin
         if (filt_v_r[i] && (filt_line_r[i] == cand_line)) hit = 1'b1;
      end
   end

   assign pf_v_o    = issuing & ~hit & ~flush_i;
   assign pf_addr_o = {cand_line, {line_offset_width_p{1'b0}}};
   assign busy_o    = issuing;
   assign dropped_o = dropped_r;

   assign handshake = pf_v_o & pf_ready_i;
   assign consume   = issuing & (handshake | hit);
   assign last      = consume & (count_r == degree_width_lp'(1));

   // A finishing stream prefers the pending slot; otherwise a same-cycle confirm loads directly.
   assign load_en     = (~issuing & accept) | (last & (pv_r | accept));
   assign load_base   = (last & pv_r) ? pend_base_r   : base_addr_i;
   assign load_stride = (last & pv_r) ? pend_stride_r : stride_i;
   assign load_degree = (last & pv_r) ? pend_degree_r : degree_clamp;
   assign pend_we     = accept & issuing & (~last | pv_r);

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_r       <= StIdle;
         cand_r        <= '0;
         stride_r      <= '0;
         count_r       <= '0;
         pv_r          <= 1'b0;
         pend_base_r   <= '0;
         pend_stride_r <= '0;
         pend_degree_r <= '0;
         filt_v_r      <= '0;
         filt_ptr_r    <= '0;
         dropped_r     <= 1'b0;
         for (int i = 0; i < int'(filter_els_p); i++) filt_line_r[i] <= '0;
      end else if (flush_i) begin
         state_r    <= StIdle;
         pv_r       <= 1'b0;
         filt_v_r   <= '0;
         filt_ptr_r <= '0;
         dropped_r  <= 1'b0;
      end else begin
         dropped_r <= accept & issuing & ~last & pv_r;

         if (handshake) begin
            filt_line_r[filt_ptr_r] <= cand_line;
            filt_v_r[filt_ptr_r]    <= 1'b1;
            filt_ptr_r <= (filt_ptr_r == ptr_width_lp'(filter_els_p - 1)) ? '0
                          : filt_ptr_r + 1'b1;
         end

         if (consume) begin
            cand_r  <= cand_r + sext(stride_r);
            count_r <= count_r - 1'b1;
         end

         if (load_en) begin
            cand_r   <= load_base + sext(load_stride);
            stride_r <= load_stride;
            count_r  <= load_degree;
            state_r  <= StIssue;
         end else if (last) begin
            state_r <= StIdle;
         end

         if (pend_we) begin
            pend_base_r   <= base_addr_i;
            pend_stride_r <= stride_i;
            pend_degree_r <= degree_clamp;
            pv_r          <= 1'b1;
         end else if (last & pv_r) begin
            pv_r <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_bp_be_prefetch_scheduler.sv
// Directed bench for bp_be_prefetch_scheduler: a queue-based stream model checked every cycle,
// plus literal address/timing expectations for each scenario.
module tb_bp_be_prefetch_scheduler;

   localparam int VA = 39;
   typedef logic [VA-1:0] va_t;

   logic        clk_i = 1'b0;
   logic        reset_i;
   logic        enable_i;
   logic [2:0]  degree_i;
   logic        confirm_v_i;
   va_t         base_addr_i;
   logic [7:0]  stride_i;
   logic        flush_i;
   logic        pf_v_o;
   va_t         pf_addr_o;
   logic        pf_ready_i;
   logic        busy_o;
   logic        dropped_o;

   int n_vec = 0;
   int n_err = 0;

   bp_be_prefetch_scheduler dut (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .enable_i    (enable_i),
      .degree_i    (degree_i),
      .confirm_v_i (confirm_v_i),
      .base_addr_i (base_addr_i),
      .stride_i    (stride_i),
      .flush_i     (flush_i),
      .pf_v_o      (pf_v_o),
      .pf_addr_o   (pf_addr_o),
      .pf_ready_i  (pf_ready_i),
      .busy_o      (busy_o),
      .dropped_o   (dropped_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endfunction

   // Model: remaining candidate addresses of the active stream, one pending stream, and the
   // recently issued lines as a bounded FIFO.
   va_t        m_cands[$];
   va_t        m_filter[$];
   bit         m_pv = 0;
   va_t        m_pbase;
   logic [7:0] m_pstride;
   int         m_pdeg;
   bit         m_dropped = 0;

   function automatic va_t line_of(va_t a);
      return {a[VA-1:6], 6'b0};
   endfunction

   function automatic void m_load(va_t base, logic [7:0] stride, int deg);
      longint s;
      s = longint'($signed(stride));
      m_cands.delete();
      for (int k = 1; k <= deg; k++) m_cands.push_back(va_t'(longint'(base) + k * s));
   endfunction

   function automatic bit m_hit();
      if (m_cands.size() == 0) return 0;
      foreach (m_filter[i]) if (m_filter[i] == line_of(m_cands[0])) return 1;
      return 0;
   endfunction

   function automatic bit m_pfv();
      return (m_cands.size() > 0) && !m_hit() && !flush_i;
   endfunction

   task automatic model_step();
      bit acc, hs, hit;
      int deg;
      if (reset_i) begin
         m_cands.delete(); m_filter.delete(); m_pv = 0; m_dropped = 0;
         return;
      end
      acc = confirm_v_i && enable_i && (degree_i != 0);
      deg = (degree_i > 4) ? 4 : int'(degree_i);
      m_dropped = 0;
      if (flush_i) begin
         m_cands.delete(); m_filter.delete(); m_pv = 0;
         return;
      end
      if (m_cands.size() > 0) begin
         hit = m_hit();
         hs  = m_pfv() && pf_ready_i;
         if (hs) begin
            m_filter.push_back(line_of(m_cands[0]));
            if (m_filter.size() > 4) void'(m_filter.pop_front());
         end
         if (hs || hit) void'(m_cands.pop_front());
         if ((hs || hit) && m_cands.size() == 0) begin
            if (m_pv) begin
               m_load(m_pbase, m_pstride, m_pdeg);
               m_pv = acc;
               if (acc) begin m_pbase = base_addr_i; m_pstride = stride_i; m_pdeg = deg; end
            end else if (acc) begin
               m_load(base_addr_i, stride_i, deg);
            end
         end else if (acc) begin
            if (m_pv) m_dropped = 1;
            m_pv = 1; m_pbase = base_addr_i; m_pstride = stride_i; m_pdeg = deg;
         end
      end else if (acc) begin
         m_load(base_addr_i, stride_i, deg);
      end
   endtask

   initial forever begin
      @(posedge clk_i);
      model_step();
   end

   va_t hs_log[$];

   // Per-cycle compare and handshake log, sampled mid-cycle.
   initial forever begin
      @(negedge clk_i);
      if (reset_i) begin
         chk("rst_pf_v", pf_v_o, 0);
         chk("rst_busy", busy_o, 0);
         chk("rst_addr", pf_addr_o, 0);
         chk("rst_dropped", dropped_o, 0);
      end else begin
         chk("pf_v", pf_v_o, m_pfv());
         chk("busy", busy_o, m_cands.size() > 0);
         chk("dropped", dropped_o, m_dropped);
         if (m_pfv()) chk("pf_addr", pf_addr_o, line_of(m_cands[0]));
         if (pf_v_o && pf_ready_i) hs_log.push_back(pf_addr_o);
      end
   end

   task automatic cyc(int n = 1);
      repeat (n) begin
         @(posedge clk_i);
         #1;
      end
   endtask

   task automatic confirm(va_t base, logic [7:0] stride, logic [2:0] deg);
      confirm_v_i = 1'b1;
      base_addr_i = base;
      stride_i    = stride;
      degree_i    = deg;
   endtask

   task automatic flush_pulse();
      flush_i = 1'b1;
      cyc();
      flush_i = 1'b0;
   endtask

   task automatic basic_stream(string tag, logic [2:0] deg);
      va_t exp_a[4] = '{39'h1040, 39'h1080, 39'h10C0, 39'h1100};
      confirm(39'h1000, 8'd64, deg);
      cyc();
      confirm_v_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk({tag, "_v"}, pf_v_o, 1);
         chk({tag, "_addr"}, pf_addr_o, exp_a[i]);
         cyc();
      end
      chk({tag, "_busy_end"}, busy_o, 0);
   endtask

   initial begin
      va_t exp_pr[6] = '{39'h1040, 39'h1080, 39'h10C0, 39'h1100, 39'h6040, 39'h6080};
      va_t exp_fl[4] = '{39'h1040, 39'h1080, 39'h10C0, 39'h1100};
      reset_i = 1'b1; enable_i = 1'b1; degree_i = 0; confirm_v_i = 0;
      base_addr_i = '0; stride_i = '0; flush_i = 0; pf_ready_i = 1'b1;
      #1;
      chk("reset_pf_v", pf_v_o, 0);
      chk("reset_busy", busy_o, 0);
      chk("reset_addr", pf_addr_o, 0);
      chk("reset_dropped", dropped_o, 0);
      cyc(2);
      reset_i = 1'b0;

      basic_stream("basic", 3'd4);

      // Backpressure on the second request
      flush_pulse();
      confirm(39'h1000, 8'd64, 3'd4);
      cyc();
      confirm_v_i = 1'b0;
      chk("bp_addr0", pf_addr_o, 39'h1040);
      cyc();
      chk("bp_addr1", pf_addr_o, 39'h1080);
      pf_ready_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("bp_hold_v", pf_v_o, 1);
         chk("bp_hold_addr", pf_addr_o, 39'h1080);
      end
      pf_ready_i = 1'b1;
      cyc();
      chk("bp_addr2", pf_addr_o, 39'h10C0);
      cyc();
      chk("bp_addr3", pf_addr_o, 39'h1100);
      cyc();
      chk("bp_busy_end", busy_o, 0);

      // Sub-line stride: one request then three filtered candidates
      flush_pulse();
      confirm(39'h2000, 8'd8, 3'd4);
      cyc();
      confirm_v_i = 1'b0;
      chk("filt_v0", pf_v_o, 1);
      chk("filt_addr0", pf_addr_o, 39'h2000);
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("filt_hit_v", pf_v_o, 0);
         chk("filt_hit_busy", busy_o, 1);
      end
      cyc();
      chk("filt_busy_end", busy_o, 0);

      // Negative stride
      confirm(39'h3000, 8'hC0, 3'd2);
      cyc();
      confirm_v_i = 1'b0;
      chk("neg_addr0", pf_addr_o, 39'h2FC0);
      cyc();
      chk("neg_addr1", pf_addr_o, 39'h2F80);
      cyc();
      chk("neg_busy_end", busy_o, 0);

      // Pending replace: B overwritten by C
      flush_pulse();
      hs_log.delete();
      confirm(39'h1000, 8'd64, 3'd4);
      cyc();
      confirm(39'h5000, 8'd64, 3'd2);
      cyc();
      chk("pr_no_drop_b", dropped_o, 0);
      confirm(39'h6000, 8'd64, 3'd2);
      cyc();
      confirm_v_i = 1'b0;
      chk("pr_drop", dropped_o, 1);
      cyc();
      chk("pr_drop_clear", dropped_o, 0);
      cyc(4);
      chk("pr_busy_end", busy_o, 0);
      chk("pr_count", hs_log.size(), 6);
      for (int i = 0; i < 6; i++) if (i < hs_log.size()) chk("pr_seq", hs_log[i], exp_pr[i]);

      // Disabled and zero-degree confirms are ignored
      enable_i = 1'b0;
      confirm(39'h7000, 8'd64, 3'd2);
      cyc();
      chk("disabled_busy", busy_o, 0);
      enable_i = 1'b1;
      confirm(39'h7000, 8'd64, 3'd0);
      cyc();
      confirm_v_i = 1'b0;
      chk("deg0_busy", busy_o, 0);

      // Flush mid-stream, then reissue the whole stream
      flush_pulse();
      confirm(39'h1000, 8'd64, 3'd4);
      cyc();
      confirm_v_i = 1'b0;
      cyc();
      flush_i = 1'b1;
      confirm(39'h8000, 8'd64, 3'd2);
      #1;
      chk("flush_pf_v", pf_v_o, 0);
      cyc();
      flush_i = 1'b0;
      confirm_v_i = 1'b0;
      chk("flush_idle", busy_o, 0);
      hs_log.delete();
      confirm(39'h1000, 8'd64, 3'd4);
      cyc();
      confirm_v_i = 1'b0;
      cyc(4);
      chk("reflush_busy_end", busy_o, 0);
      chk("reflush_count", hs_log.size(), 4);
      for (int i = 0; i < 4; i++) if (i < hs_log.size()) chk("reflush_seq", hs_log[i], exp_fl[i]);

      // Asynchronous reset mid-stream
      confirm(39'h9000, 8'd64, 3'd4);
      cyc();
      confirm_v_i = 1'b0;
      cyc();
      reset_i = 1'b1;
      #1;
      chk("areset_pf_v", pf_v_o, 0);
      chk("areset_busy", busy_o, 0);
      chk("areset_addr", pf_addr_o, 0);
      cyc(2);
      reset_i = 1'b0;
      basic_stream("post_reset", 3'd7);

      cyc(2);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, vectors %0d", n_vec);
      $fatal(1);
   end

endmodule

// File: doc/bp_be_prefetch_scheduler.md
# bp_be_prefetch_scheduler

Sequences prefetch requests for the backend from confirmed stride streams. On each confirmed (address, stride) detection it issues up to `degree_i` cache-line-aligned prefetch addresses (base+stride, base+2·stride, …) on a valid/ready port to the D$ prefetch path. It holds one pending stream while busy and suppresses lines it issued recently.

## Interface
- `vaddr_width_p`, proc param: virtual address width.
- `stride_width_p`, 8: signed stride width in bytes.
- `degree_max_p`, 4: maximum prefetches per stream.
- `filter_els_p`, 4: recently-issued line filter depth.
- `line_offset_width_p`, 6: log2 cache line bytes (64 B).
- `clk_i`  in  1  clock, posedge.
- `reset_i`  in  1  asynchronous, active-high reset.
- `enable_i`  in  1  low: ignore confirms (an in-flight stream still completes).
- `degree_i`  in  $clog2(degree_max_p+1)  prefetch degree, sampled at confirm acceptance; values >degree_max_p clamp to it.
- `confirm_v_i`  in  1  confirmed stream detection strobe.
- `base_addr_i`  in  vaddr_width_p  last demand effective address of the stream.
- `stride_i`  in  stride_width_p  signed byte stride.
- `flush_i`  in  1  synchronous abort of all prefetch state.
- `pf_v_o`  out  1  prefetch request valid.
- `pf_addr_o`  out  vaddr_width_p  line-aligned prefetch address (low offset bits zero).
- `pf_ready_i`  in  1  consumer accepts the request.
- `busy_o`  out  1  state is ISSUE.
- `dropped_o`  out  1  one-cycle pulse: a pending stream was overwritten.

## Operation
- States: IDLE, ISSUE. Registers: `cand_r` (vaddr), `stride_r`, `count_r` (remaining candidates), pending {`pv_r`, base, stride, degree}, and a filter of `filter_els_p` valid+line-address entries replaced FIFO-style.
- Confirm acceptance requires `confirm_v_i & enable_i & degree_i!=0`. Otherwise it is ignored.
- Load stream: `cand_r <= base + sext(stride)`, `count_r <= degree`, state ISSUE.
- Address arithmetic is modulo 2^vaddr_width_p. Wrap is silent. Stride is sign-extended.
- `hit` = line(`cand_r`) matches any valid filter entry.
- `pf_v_o = (state==ISSUE) & ~hit & ~flush_i`. `pf_addr_o` = line(`cand_r`).
- A candidate is consumed on a handshake (`pf_v_o & pf_ready_i`) or on a filter hit in ISSUE. Consuming advances `cand_r += sext(stride_r)` and decrements `count_r`.
- On a handshake, the line is pushed into the filter, overwriting the oldest entry.
- Last candidate consumed (`count_r==1`):
  - If `pv_r`, load the pending stream and clear `pv_r`.
  - Else, if an accepted confirm arrives this cycle, load it directly.
  - Else go to IDLE.
  - If `pv_r` and a new confirm arrive together, load the old pending stream and write the new one to pending. Nothing is dropped.
- In IDLE, an accepted confirm loads directly.
- In ISSUE and not finishing, an accepted confirm writes pending. If `pv_r` was already set, the old pending stream is replaced and `dropped_o` pulses the next cycle.
- `flush_i` has highest priority:
  - `pf_v_o` is forced low that cycle, so no handshake occurs.
  - Next state is IDLE; `pv_r` and all filter valids are cleared.
  - A confirm in the same cycle is discarded.
- Stride 0: every candidate maps to the same line, so at most one request is issued per stream.
- `pf_addr_o` and `cand_r` hold stable while `pf_v_o & ~pf_ready_i`.

## Timing
- Reset (asynchronous, takes effect immediately) sets state IDLE, `cand_r`=0, `count_r`=0, `pv_r`=0, filter invalid.
- Output values during reset: `pf_v_o`=0, `pf_addr_o`=0, `busy_o`=0, `dropped_o`=0.
- Confirm at cycle t gives `pf_v_o` at t+1 at the earliest.
- With `pf_ready_i` held high and no filter hits, one request issues per cycle, and `busy_o` falls the cycle after the last handshake.
- Each filtered candidate costs one cycle with `pf_v_o`=0.
- A back-to-back stream switch costs no bubble.
- `pf_v_o`/`pf_addr_o` are combinational from state (`hit`, `flush_i`). `dropped_o` is registered.

## Test plan
- Basic stream: degree 4, base 0x1000, stride 64, ready=1 → `pf_addr_o` 0x1040, 0x1080, 0x10C0, 0x1100 on t+1..t+4; `busy_o` low at t+5.
- Backpressure: same stream, `pf_ready_i`=0 for 3 cycles on the 2nd request → 0x1080 held stable with `pf_v_o`=1; sequence completes afterwards.
- Filter and negative stride:
  - Base 0x2000, stride 8, degree 4 → single request 0x2000, then 3 filtered cycles.
  - Then base 0x3000, stride −64 (0xC0), degree 2 → 0x2FC0, 0x2F80.
- Pending replace: confirm A (0x1000/64/4), then B and C during ISSUE → `dropped_o` pulses once after C; A's four lines issue, then C's. No B addresses appear.
- Flush mid-stream: flush after the first handshake of A → `pf_v_o`=0 in the flush cycle and IDLE next; re-confirming A reissues all 4 lines (filter cleared).
- Async reset asserted mid-ISSUE with no clock edge → `pf_v_o`, `busy_o`, `pf_addr_o` go to 0 immediately; the first confirm after deassertion behaves as the basic stream.
